// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit and its HI/LO registers.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MFHI  = 3'd4,
    MD_MFLO  = 3'd5,
    MD_MTHI  = 3'd6,
    MD_MTLO  = 3'd7
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    FIXUP = 2'd2
  } md_state_t;

  localparam int MD_ITERATIONS = 32;

endpackage

// File: rtl/muldiv_if.sv
// EX-stage to mul/div request bundle, with the unit's status and read-back result.
interface muldiv_if #(
  parameter int MD_OP_WIDTH = 3
);
  // A request transfers on a clock edge where op_valid=1 and stall=0; stall acts
  // as an inverted ready. While stall=1 the requester holds op_valid, md_op, A and B.
  logic                   op_valid;
  logic [MD_OP_WIDTH-1:0] md_op;
  logic [31:0]            A;
  logic [31:0]            B;
  logic                   flush;
  logic                   stall;
  logic                   busy;
  logic                   done;
  logic [31:0]            result;
  logic [1:0]             state_dbg;

  modport master (
    output op_valid, md_op, A, B, flush,
    input  stall, busy, done, result, state_dbg
  );

  modport slave (
    input  op_valid, md_op, A, B, flush,
    output stall, busy, done, result, state_dbg
  );

endinterface

// File: rtl/muldiv_core.sv
// One-bit-per-cycle step datapath: radix-2 shift-add multiply and restoring divide
// sharing a single 64-bit accumulator. Sequenced by muldiv_unit.
module muldiv_core
  import muldiv_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        step_i,
  input  logic        is_div_i,
  input  logic [31:0] a_mag_i,
  input  logic [31:0] b_mag_i,
  output logic [63:0] acc_o
);

  logic [63:0] acc_q, acc_d;
  logic [31:0] opnd_q, opnd_d;
  logic [32:0] add_sum;
  logic [32:0] shifted;
  logic [32:0] sub_rem;

  // Multiply keeps the multiplier in acc[31:0] and shifts the partial product in
  // from the top; divide keeps remainder in acc[63:32] and the dividend/quotient below.
  always_comb begin
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    add_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    shifted = acc_q[63:31];
    sub_rem = shifted - {1'b0, opnd_q};
    if (load_i) begin
      acc_d  = is_div_i ? {32'd0, a_mag_i} : {32'd0, b_mag_i};
      opnd_d = is_div_i ? b_mag_i : a_mag_i;
    end else if (step_i) begin
      if (is_div_i) begin
        // The shifted remainder is always below twice the divisor, so bit 32 is a clean borrow.
        acc_d = sub_rem[32] ? {shifted[31:0], acc_q[30:0], 1'b0}
                            : {sub_rem[31:0], acc_q[30:0], 1'b1};
      end else begin
        acc_d = {add_sum, acc_q[31:1]};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q  <= '0;
      opnd_q <= '0;
    end else begin
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/muldiv_unit.sv
// Mul/div sequencer owning HI/LO; IDLE -> ITER (32 steps) -> FIXUP, stalling EX while busy.
// Optional MULDIV_EARLY_OUT_EN: multiplies leave ITER once the multiplier is exhausted, and divide by zero skips ITER.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int MD_OP_WIDTH = 3,
  parameter int COUNT_WIDTH = 6
) (
  input logic    clock,
  input logic    reset,
  muldiv_if.slave md
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_ITER  = ITER;
  localparam logic [1:0] ST_FIXUP = FIXUP;
  localparam logic [COUNT_WIDTH-1:0] LAST_STEP = COUNT_WIDTH'(MD_ITERATIONS - 1);

  logic [1:0]             state_q, state_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [31:0]            hi_q, hi_d;
  logic [31:0]            lo_q, lo_d;
  logic                   res_neg_q, res_neg_d;
  logic                   rem_neg_q, rem_neg_d;
  logic                   is_div_q, is_div_d;
  logic                   div_zero_q, div_zero_d;
  logic [31:0]            orig_a_q, orig_a_d;

  logic [MD_OP_WIDTH-1:0] op_raw;
  md_op_t                 op;
  logic                   is_signed, is_muldiv, new_is_div;
  logic                   a_neg, b_neg;
  logic [31:0]            a_mag, b_mag;
  logic                   accept;
  logic                   core_load, core_step, core_is_div;
  logic [63:0]            core_acc;
  logic [63:0]            prod_mag, prod;
  logic [31:0]            quo, rem, div_lo, div_hi;

`ifdef MULDIV_EARLY_OUT_EN
  logic [COUNT_WIDTH-1:0] align_sh;
  logic [31:0]            mul_rest;
`endif

  assign op_raw = md.md_op;

  always_comb begin
    op         = md_op_t'(op_raw);
    is_signed  = (op == MD_MULT) || (op == MD_DIV);
    new_is_div = (op == MD_DIV) || (op == MD_DIVU);
    is_muldiv  = (op == MD_MULT) || (op == MD_MULTU) || new_is_div;
    a_neg      = is_signed & md.A[31];
    b_neg      = is_signed & md.B[31];
    a_mag      = a_neg ? (~md.A + 32'd1) : md.A;
    b_mag      = b_neg ? (~md.B + 32'd1) : md.B;
    // flush in an IDLE cycle drops whatever EX presents
    accept     = md.op_valid && (state_q == ST_IDLE) && !md.flush;
  end

  assign core_is_div = (state_q == ST_IDLE) ? new_is_div : is_div_q;

  muldiv_core u_core (
    .clk_i   (clock),
    .rst_i   (reset),
    .load_i  (core_load),
    .step_i  (core_step),
    .is_div_i(core_is_div),
    .a_mag_i (a_mag),
    .b_mag_i (b_mag),
    .acc_o   (core_acc)
  );

  // Sign fixup and the special divide cases, consumed in FIXUP.
  always_comb begin
`ifdef MULDIV_EARLY_OUT_EN
    // An early exit leaves the product short of its final position by the skipped steps.
    align_sh = COUNT_WIDTH'(MD_ITERATIONS) - count_q;
    prod_mag = core_acc >> align_sh;
    mul_rest = (core_acc[31:0] >> 1) & (32'hFFFF_FFFF >> (count_q + 1'b1));
`else
    prod_mag = core_acc;
`endif
    prod   = res_neg_q ? (~prod_mag + 64'd1) : prod_mag;
    quo    = res_neg_q ? (~core_acc[31:0] + 32'd1) : core_acc[31:0];
    rem    = rem_neg_q ? (~core_acc[63:32] + 32'd1) : core_acc[63:32];
    div_lo = div_zero_q ? 32'hFFFF_FFFF : quo;
    div_hi = div_zero_q ? orig_a_q : rem;
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    res_neg_d  = res_neg_q;
    rem_neg_d  = rem_neg_q;
    is_div_d   = is_div_q;
    div_zero_d = div_zero_q;
    orig_a_d   = orig_a_q;
    core_load  = 1'b0;
    core_step  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (op == MD_MTHI) begin
            hi_d = md.A;
          end else if (op == MD_MTLO) begin
            lo_d = md.A;
          end else if (is_muldiv) begin
            core_load  = 1'b1;
            count_d    = '0;
            res_neg_d  = a_neg ^ b_neg;
            rem_neg_d  = a_neg;
            is_div_d   = new_is_div;
            div_zero_d = (md.B == 32'd0);
            orig_a_d   = md.A;
            state_d    = ST_ITER;
`ifdef MULDIV_EARLY_OUT_EN
            if (new_is_div && (md.B == 32'd0)) state_d = ST_FIXUP;
`endif
          end
        end
      end
      ST_ITER: begin
        if (md.flush) begin
          state_d = ST_IDLE;
        end else begin
          core_step = 1'b1;
          count_d   = count_q + 1'b1;
          if (count_q == LAST_STEP) begin
            state_d = ST_FIXUP;
          end
`ifdef MULDIV_EARLY_OUT_EN
          else if (!is_div_q && (mul_rest == 32'd0)) begin
            state_d = ST_FIXUP;
          end
`endif
        end
      end
      ST_FIXUP: begin
        state_d = ST_IDLE;
        if (!md.flush) begin
          hi_d = is_div_q ? div_hi : prod[63:32];
          lo_d = is_div_q ? div_lo : prod[31:0];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      res_neg_q  <= 1'b0;
      rem_neg_q  <= 1'b0;
      is_div_q   <= 1'b0;
      div_zero_q <= 1'b0;
      orig_a_q   <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      res_neg_q  <= res_neg_d;
      rem_neg_q  <= rem_neg_d;
      is_div_q   <= is_div_d;
      div_zero_q <= div_zero_d;
      orig_a_q   <= orig_a_d;
    end
  end

  assign md.stall     = !reset && md.op_valid && (state_q != ST_IDLE);
  assign md.busy      = (state_q != ST_IDLE);
  assign md.done      = !reset && (state_q == ST_FIXUP) && !md.flush;
  assign md.state_dbg = state_q;

  always_comb begin
    md.result = 32'd0;
    if (!reset && accept) begin
      if (op == MD_MFHI) md.result = hi_q;
      else if (op == MD_MFLO) md.result = lo_q;
    end
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide sequencer that owns the architectural HI/LO registers.
- Sits beside the EX-stage ALU and receives already-forwarded A/B operands from EX.
- Sequences one MULT/MULTU/DIV/DIVU over 32 iteration cycles plus one sign-fixup cycle.
- Arbitrates MFHI/MFLO/MTHI/MTLO access, raising stall to freeze the pipeline while HI/LO are in flight.

Parameters:
- MD_OP_WIDTH, 3, width of the md_op encoding.
- COUNT_WIDTH, 6, width of the iteration counter (must hold 32).

Ports:
- clock  input  1  pipeline clock.
- reset  input  1  synchronous, active-high reset.
- op_valid  input  1  EX presents a mul/div/HI-LO instruction this cycle.
- md_op  input  MD_OP_WIDTH  operation encoding (md_op_t).
- A  input  32  forwarded rs value.
- B  input  32  forwarded rt value.
- flush  input  1  kill the in-flight mul/div (exception/squash).
- stall  output  1  op_valid request not accepted this cycle; the pipeline must hold EX.
- busy  output  1  a mul/div is in progress.
- done  output  1  one-cycle pulse in the FIXUP cycle.
- result  output  32  HI or LO for MFHI/MFLO, otherwise 0.

Behaviour:
- Reset (synchronous, takes priority over everything):
  - HI=LO=0, state=IDLE, counter=0, busy=0, done=0.
  - stall=0 and result=0 while reset is asserted.
- States:
  - IDLE: accept any op.
  - ITER: 32 iterations, one per cycle.
  - FIXUP: sign correction and HI/LO write.
- Acceptance:
  - An op is accepted when op_valid=1 and state==IDLE; stall=0 in the accept cycle.
  - When op_valid=1 and state!=IDLE, stall=1 combinationally and nothing is captured. This applies to every md_op, including MFHI/MFLO/MTHI/MTLO.
- MULT/MULTU/DIV/DIVU accepted in cycle T:
  - Cycle T: latch operands. Signed ops latch |A|, |B| and the result signs.
  - Cycles T+1..T+32: ITER.
  - Cycle T+33: FIXUP with done=1; HI/LO are written at the end of T+33.
  - Cycle T+34: IDLE; new HI/LO are readable.
  - busy=1 from T+1 through T+33.
- MULT datapath:
  - Radix-2 shift-add on a 64-bit accumulator.
  - FIXUP negates the 64-bit product when the sign of A differs from the sign of B (signed op only).
  - HI=product[63:32], LO=product[31:0].
- DIV datapath:
  - Restoring division, 1 quotient bit per cycle.
  - FIXUP negates the quotient when the sign of A differs from the sign of B.
  - FIXUP negates the remainder when A is negative.
  - LO=quotient, HI=remainder.
- Divide by zero (both signedness): LO=0xFFFFFFFF, HI=original A, with no sign fixup. Counts a full 32 iterations.
- Signed overflow 0x80000000 / -1: LO=0x80000000, HI=0.
- MFHI/MFLO in IDLE: result=HI or LO combinationally in the same cycle; no state change.
- MTHI/MTLO in IDLE: HI or LO takes A at the next edge.
- flush:
  - In ITER/FIXUP: next state is IDLE, HI/LO unchanged, done is not asserted in the following cycle.
  - If flush and op_valid occur in the same IDLE cycle, flush wins: the op is dropped and stall=0.
- Simultaneous FIXUP and new op_valid: the op is stalled and is accepted the next cycle, when it sees the updated HI/LO.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- When defined:
  - In ITER for MULT/MULTU, when the remaining multiplier bits are all zero, go directly to FIXUP. The accumulator is aligned with a single final shift.
  - Division by zero skips ITER entirely: T+1 is FIXUP.
- When undefined: fixed 34-cycle latency for every mul/div.
- Results are identical either way; only the timing differs.

Decomposition:
- muldiv_pkg holds:
  - typedef md_op_t: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MFHI, MD_MFLO, MD_MTHI, MD_MTLO.
  - typedef md_state_t: IDLE, ITER, FIXUP.
  - localparam MD_ITERATIONS=32.
- One sub-module, muldiv_core: the shift-add/restoring-subtract step datapath, driven by the FSM in muldiv_unit.

Test Plan:
1. MULTU A=0xFFFFFFFF, B=0xFFFFFFFF accepted at T → done only at T+33; at T+34 HI=0xFFFFFFFE, LO=0x00000001.
2. MULT A=0xFFFFFFFD (-3), B=7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. DIV A=0xFFFFFFF9 (-7), B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
3. DIVU A=7, B=0 → LO=0xFFFFFFFF, HI=0x00000007. DIV A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
4. MFLO held valid from T+1 after a MULT → stall=1 for T+1..T+33; at T+34 stall=0 and result equals the new LO.
5. Reset asserted mid-DIV (iteration 10) → next cycle busy=0, HI=LO=0. Separately, with HI=0x11 loaded by MTHI, flush mid-MULT → HI stays 0x11 and done is never pulsed.
6. With MULDIV_EARLY_OUT_EN: MULTU A=5, B=3 → done within 4 cycles of accept, HI=0, LO=15. Without the macro → done at T+33 with the same values.
